// File: rtl/count_led_display.sv
// Samples the shared-clock 4-bit counter once per prescaler period and shows
// the captured value on PWM-dimmed LEDs, with a heartbeat and sticky overrun flag.
module count_led_display #(
  parameter int WIDTH     = 4,
  parameter int DIV_WIDTH = 23,
  parameter int PWM_BITS  = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                RDY_count_value,
  input  logic [WIDTH-1:0]    count_value,
  output logic                EN_count_value,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [WIDTH-1:0]    leds,
  output logic                heartbeat,
  output logic                overrun
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [PWM_BITS-1:0]  PWM_ONE = PWM_BITS'(1);

  logic [DIV_WIDTH-1:0] r_prescaler;
  logic [PWM_BITS-1:0]  r_pwmCnt;
  logic [PWM_BITS-1:0]  r_duty;
  logic [WIDTH-1:0]     r_shown;
  logic [WIDTH-1:0]     r_leds;
  logic [0:0]           r_state;
  logic                 r_enLast;
  logic                 r_heartbeat;
  logic                 r_overrun;

  logic                 w_tick;
  logic                 w_capture;
  logic                 w_on;
  logic [WIDTH-1:0]     w_shownNext;

  assign w_tick = (r_prescaler == '1);

  // r_enLast blocks a second pulse when a tick re-enters REQ on the completing cycle
  assign w_capture      = (r_state == REQ) & RDY_count_value & ~r_enLast;
  assign EN_count_value = w_capture;

  assign w_on        = (r_duty == '1) ? 1'b1 : (r_pwmCnt < r_duty);
  assign w_shownNext = w_capture ? count_value : r_shown;

  assign leds      = r_leds;
  assign heartbeat = r_heartbeat;
  assign overrun   = r_overrun;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_prescaler <= '0;
      r_pwmCnt    <= '0;
      r_duty      <= '0;
    end else begin
      r_prescaler <= r_prescaler + DIV_ONE;
      r_pwmCnt    <= r_pwmCnt + PWM_ONE;
      if (r_pwmCnt == '1) begin
        r_duty <= brightness;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_enLast    <= 1'b0;
      r_shown     <= '0;
      r_leds      <= '0;
      r_heartbeat <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_enLast <= w_capture;
      r_shown  <= w_shownNext;
      // leds take the freshly captured value on the capture edge itself
      r_leds   <= w_shownNext & {WIDTH{w_on}};
      if (w_capture) begin
        r_heartbeat <= ~r_heartbeat;
      end
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_state <= REQ;
          end
        end
        REQ: begin
          if (w_capture) begin
            r_state <= w_tick ? REQ : IDLE;
          end else if (w_tick) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
